// File: rtl/serial_tofed_cntr.sv
// Serial 3-of-5 code checker: counts bits and ones per 5-bit word and
// registers whether each completed word held exactly three ones.

package SerialTOFEDDefs;
    localparam int FBIBBLE_SIZE   = 5;
    localparam int ONESPERFBIBBLE = 3;

    typedef enum logic {
        FALSE = 1'b0,
        TRUE  = 1'b1
    } bool_t;
endpackage

module serial_tofed_cntr
    import SerialTOFEDDefs::*;
(
    input  logic  clk,
    input  logic  resetL,
    input  logic  din,
    output bool_t valid
);

    localparam int BIT_W  = $clog2(FBIBBLE_SIZE);
    localparam int ONES_W = $clog2(FBIBBLE_SIZE + 1);

    logic [BIT_W-1:0]  r_bit_cnt;
    logic [ONES_W-1:0] r_ones_cnt;
    bool_t             r_valid;

    logic              w_last_bit;
    logic [ONES_W-1:0] w_ones_sum;

    assign w_last_bit = (r_bit_cnt == BIT_W'(FBIBBLE_SIZE - 1));
    // At most FBIBBLE_SIZE ones including the final bit, so ONES_W never wraps.
    assign w_ones_sum = r_ones_cnt + ONES_W'(din);

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetL) begin
        if (!resetL) begin
            r_bit_cnt  <= '0;
            r_ones_cnt <= '0;
            r_valid    <= FALSE;
        end else if (w_last_bit) begin
            r_bit_cnt  <= '0;
            r_ones_cnt <= '0;
            r_valid    <= (w_ones_sum == ONES_W'(ONESPERFBIBBLE)) ? TRUE : FALSE;
        end else begin
            r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
            r_ones_cnt <= w_ones_sum;
        end
    end

    assign valid = r_valid;

endmodule

// File: tb/tb_serial_tofed_cntr.sv
// Directed self-checking bench for serial_tofed_cntr: reset, single words,
// exhaustive 5-bit codes, back-to-back transitions and mid-word reset.

module tb_serial_tofed_cntr;
    import SerialTOFEDDefs::*;

    logic  clk;
    logic  resetL;
    logic  din;
    bool_t valid;

    int n_checks;
    int n_fail;
    int n_true;

    serial_tofed_cntr dut (
        .clk    (clk),
        .resetL (resetL),
        .din    (din),
        .valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        din = b;
        @(posedge clk);
        #1;
    endtask

    // Bits go out MSB first; valid must hold exp_prev for the first four
    // edges and switch to exp_new on the final-bit edge.
    task automatic send_word(input string tag, input logic [4:0] w,
                             input logic exp_prev, input logic exp_new);
        for (int i = 4; i >= 0; i--) begin
            send_bit(w[i]);
            if (i != 0) check($sformatf("%s_hold%0d", tag, 4 - i), 32'(valid), 32'(exp_prev));
            else        check($sformatf("%s_final", tag), 32'(valid), 32'(exp_new));
        end
    endtask

    initial begin
        logic prev;
        logic exp;
        logic [4:0] code;

        n_checks = 0;
        n_fail   = 0;
        n_true   = 0;
        resetL   = 1'b0;
        din      = 1'b0;

        // Reset held for two clocks with din toggling
        for (int i = 0; i < 4; i++) begin
            din = ~din;
            #5;
            check($sformatf("rst_valid%0d", i), 32'(valid), 32'(FALSE));
        end
        check("rst_bitcnt", 32'(dut.r_bit_cnt), 32'd0);
        check("rst_onescnt", 32'(dut.r_ones_cnt), 32'd0);
        @(posedge clk);
        #1;
        resetL = 1'b1;

        // Valid word, then one that keeps valid TRUE for five more clocks
        send_word("w11100", 5'b11100, 1'b0, 1'b1);
        send_word("w10101", 5'b10101, 1'b1, 1'b1);

        // Boundary words
        send_word("w00000", 5'b00000, 1'b1, 1'b0);
        send_word("w11111", 5'b11111, 1'b0, 1'b0);
        send_word("w11000", 5'b11000, 1'b0, 1'b0);
        send_word("w11110", 5'b11110, 1'b0, 1'b0);

        // Exhaustive: all 32 codes back to back plus trailing 00000
        prev = 1'b0;
        for (int c = 0; c < 32; c++) begin
            code = 5'(c);
            exp  = ($countones(code) == 3);
            if (exp) n_true++;
            send_word($sformatf("ex%02h", c), code, prev, exp);
            prev = exp;
        end
        check("ex_true_count", 32'(n_true), 32'd10);
        send_word("ex_trail", 5'b00000, prev, 1'b0);

        // Back-to-back transitions
        send_word("b2b_01011", 5'b01011, 1'b0, 1'b1);
        send_word("b2b_01001", 5'b01001, 1'b1, 1'b0);

        // Mid-word reset: valid TRUE beforehand, partial 1,1 discarded
        send_word("mid_pre", 5'b11010, 1'b0, 1'b1);
        send_bit(1'b1);
        check("mid_p0", 32'(valid), 32'(TRUE));
        send_bit(1'b1);
        check("mid_p1", 32'(valid), 32'(TRUE));
        #3;
        resetL = 1'b0;
        #1;
        check("mid_async", 32'(valid), 32'(FALSE));
        check("mid_bitcnt", 32'(dut.r_bit_cnt), 32'd0);
        check("mid_onescnt", 32'(dut.r_ones_cnt), 32'd0);
        @(posedge clk);
        #1;
        resetL = 1'b1;
        send_word("mid_01011", 5'b01011, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
